hp_write_monitor: RTL and testbench
===================================

// Module: hp_write_monitor
// PURPOSE
//  Write-path guard between the ADC DMA AXI3 master and the PS HP0 slave port.
//  Gates AW so that at most MAX_OUTSTANDING bursts are in flight without a write response.
//  Passively taps the W and B channels and checks each burst's beat count against its awlen.
//  Raises sticky error flags and an irq pulse for the PS interrupt vector.
// PARAMETERS
//  MAX_OUTSTANDING  8  bursts in flight (AW accepted, B not yet seen); legal range 1..16
//  LEN_W            4  awlen width (AXI3)
//  CNT_W            $clog2(MAX_OUTSTANDING+1)  localparam, width of the outstanding counter
// PORTS
//  axi_aclk     in   1      clock for all logic
//  axi_areset   in   1      synchronous, active-high reset
//  s_awvalid    in   1      AW valid from the DMA
//  s_awready    out  1      AW ready to the DMA
//  s_awlen      in   LEN_W  AW length from the DMA (beats-1)
//  m_awvalid    out  1      AW valid to HP0
//  m_awready    in   1      AW ready from HP0
//  mon_wvalid   in   1      W valid tap
//  mon_wready   in   1      W ready tap
//  mon_wlast    in   1      W last tap
//  mon_bvalid   in   1      B valid tap
//  mon_bready   in   1      B ready tap
//  mon_bresp    in   2      B response tap
//  clear        in   1      one-cycle clear of sticky errors (and stats)
//  outstanding  out  CNT_W  bursts currently in flight
//  err_wlast    out  1      sticky: wlast/beat-count mismatch, or W beat with no burst queued
//  err_bresp    out  1      sticky: bresp != OKAY
//  err_orphan_b out  1      sticky: B handshake while outstanding==0
//  irq          out  1      one-cycle pulse on any error bit rising 0->1
// BEHAVIOUR
//  - Reset: all registered outputs 0, FIFO empty, beat counter 0.
//  - allow = (outstanding < MAX_OUTSTANDING) && !fifo_full; allow is derived from registers only.
//  - m_awvalid = s_awvalid & allow; s_awready = m_awready & allow. Zero latency, no combinational loop.
//  - Handshakes: aw_hs = m_awvalid & m_awready; w_hs = mon_wvalid & mon_wready; b_hs = mon_bvalid & mon_bready.
//  - Outstanding counter: +1 on aw_hs, -1 on b_hs; unchanged when both occur in the same cycle.
//    - b_hs with outstanding==0 and no aw_hs: counter holds at 0 and err_orphan_b is set.
//  - Length FIFO: s_awlen is pushed on aw_hs; the head is popped when a burst ends.
//    - Pointers wrap modulo MAX_OUTSTANDING.
//    - Push and pop in the same cycle are legal.
//  - Head length: FIFO head if not empty; s_awlen if empty and aw_hs this cycle (bypass); otherwise none.
//  - On w_hs with a head length present, the burst ends when mon_wlast=1 OR beat==head.
//    - On burst end: pop the head, set beat=0.
//    - err_wlast is set unless both conditions hold together.
//    - Otherwise beat increments.
//  - w_hs with no head length: err_wlast is set; beat and FIFO are unchanged (AW precedes W in this system).
//  - b_hs with mon_bresp != OKAY: err_bresp is set.
//  - Error bit update: err <= (err & ~clear) | new_err. A set in the same cycle as clear wins.
//  - irq is registered: 1 in the cycle after any error bit transitions 0->1.
//  - Reset mid-burst: all state is discarded; tracking restarts empty.
// CONFIGURATION
//  HP_WRITE_MONITOR_STATS_EN defined:
//    - Adds ports beat_count out 32 (counts w_hs) and burst_count out 32 (counts aw_hs).
//    - Both counters reset to 0, are cleared by clear, and wrap from 2^32-1 to 0.
//  HP_WRITE_MONITOR_STATS_EN undefined: those ports and counters do not exist.
// STRUCTURE
//  hp_write_monitor_pkg holds:
//    - BRESP_OKAY=2'b00, BRESP_EXOKAY=2'b01, BRESP_SLVERR=2'b10, BRESP_DECERR=2'b11
//    - DEFAULT_MAX_OUTSTANDING=8
//  Sub-module hp_len_fifo: synchronous FIFO, depth MAX_OUTSTANDING, width LEN_W.
//    - Outputs: head, empty, full.
//    - Ignores push when full and pop when empty.
// TESTING
//  - Issue 8 AW (len=3) with m_awready=1 and no B -> 9th AW stalls (s_awready=0, m_awvalid=0), outstanding=8;
//    one OKAY B -> AW accepted the next cycle.
//  - AW and first W beat in the same cycle with empty FIFO (len=0, wlast=1) -> no error, FIFO empty afterwards.
//  - awlen=3, wlast on 3rd beat -> err_wlast=1, irq pulses once;
//    the following correct burst raises no new irq.
//  - B with bresp=2'b10 -> err_bresp=1; clear held in the same cycle as a new SLVERR -> err_bresp stays 1.
//  - B handshake at outstanding=0 -> err_orphan_b=1, outstanding stays 0;
//    AW and B in the same cycle at outstanding=5 -> stays 5.
//  - STATS_EN build: 2 bursts of len=15 -> beat_count=32, burst_count=2; clear -> both 0.

Source files
------------

// File: rtl/hp_write_monitor_pkg.sv
// rtl/hp_write_monitor_pkg.sv - shared constants for the HP0 write-path monitor
package hp_write_monitor_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam int DEFAULT_MAX_OUTSTANDING = 8;

endpackage

// File: rtl/hp_write_monitor_len_fifo.sv
// rtl/hp_write_monitor_len_fifo.sv - hp_len_fifo: synchronous awlen FIFO, pointers wrap modulo DEPTH
module hp_len_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents are only meaningful while count covers them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; push and pop in one cycle keep count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hp_write_monitor.sv
// rtl/hp_write_monitor.sv - AW gate plus W/B checker for the ADC DMA to HP0 path (option: HP_WRITE_MONITOR_STATS_EN)
module hp_write_monitor
  import hp_write_monitor_pkg::*;
#(
  parameter int  MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int  LEN_W           = 4,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             axi_aclk,
  input  logic             axi_areset,
  input  logic             s_awvalid,
  output logic             s_awready,
  input  logic [LEN_W-1:0] s_awlen,
  output logic             m_awvalid,
  input  logic             m_awready,
  input  logic             mon_wvalid,
  input  logic             mon_wready,
  input  logic             mon_wlast,
  input  logic             mon_bvalid,
  input  logic             mon_bready,
  input  logic [1:0]       mon_bresp,
  input  logic             clear,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_wlast,
  output logic             err_bresp,
  output logic             err_orphan_b,
  output logic             irq
`ifdef HP_WRITE_MONITOR_STATS_EN
  ,
  output logic [31:0]      beat_count,
  output logic [31:0]      burst_count
`endif
);

  logic             fifo_empty;
  logic             fifo_full;
  logic [LEN_W-1:0] fifo_head;
  logic             fifo_push;
  logic             fifo_pop;

  logic             allow;
  logic             aw_hs;
  logic             w_hs;
  logic             b_hs;

  logic [LEN_W-1:0] beat;
  logic [LEN_W-1:0] head_len;
  logic             has_head;
  logic             bypass;
  logic             beat_match;
  logic             burst_end;

  logic             set_wlast;
  logic             set_bresp;
  logic             set_orphan;
  logic             err_wlast_nxt;
  logic             err_bresp_nxt;
  logic             err_orphan_nxt;

  // Gate uses registered state only, so AW ready/valid never loop through each other.
  assign allow     = (outstanding < CNT_W'(MAX_OUTSTANDING)) && !fifo_full;
  assign m_awvalid = s_awvalid & allow;
  assign s_awready = m_awready & allow;

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = mon_wvalid & mon_wready;
  assign b_hs  = mon_bvalid & mon_bready;

  // An AW accepted into an empty FIFO can be consumed by a W beat in the same cycle.
  assign bypass     = fifo_empty & aw_hs;
  assign has_head   = !fifo_empty || aw_hs;
  assign head_len   = fifo_empty ? s_awlen : fifo_head;
  assign beat_match = (beat == head_len);
  assign burst_end  = w_hs & has_head & (mon_wlast | beat_match);

  // A bypassed burst that finishes immediately never enters the FIFO.
  assign fifo_push = aw_hs & ~(bypass & burst_end);
  assign fifo_pop  = burst_end & ~fifo_empty;

  assign set_wlast  = w_hs & (~has_head | (burst_end & ~(mon_wlast & beat_match)));
  assign set_bresp  = b_hs & (mon_bresp != BRESP_OKAY);
  assign set_orphan = b_hs & ~aw_hs & (outstanding == '0);

  // A new error in the clear cycle survives the clear.
  assign err_wlast_nxt  = (err_wlast & ~clear) | set_wlast;
  assign err_bresp_nxt  = (err_bresp & ~clear) | set_bresp;
  assign err_orphan_nxt = (err_orphan_b & ~clear) | set_orphan;

  hp_len_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .clk   (axi_aclk),
    .rst   (axi_areset),
    .push  (fifo_push),
    .din   (s_awlen),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Bursts in flight: AW adds, B removes, an orphan B cannot underflow.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      outstanding <= '0;
    end else if (aw_hs && !b_hs) begin
      outstanding <= outstanding + 1'b1;
    end else if (b_hs && !aw_hs && (outstanding != '0)) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // Beat position within the current burst; untouched by beats with no burst queued.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      beat <= '0;
    end else if (w_hs && has_head) begin
      beat <= burst_end ? '0 : beat + 1'b1;
    end
  end

  // Sticky error flags plus a one-cycle irq on any 0->1 flag transition.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      err_wlast    <= 1'b0;
      err_bresp    <= 1'b0;
      err_orphan_b <= 1'b0;
      irq          <= 1'b0;
    end else begin
      err_wlast    <= err_wlast_nxt;
      err_bresp    <= err_bresp_nxt;
      err_orphan_b <= err_orphan_nxt;
      irq          <= (err_wlast_nxt & ~err_wlast) |
                      (err_bresp_nxt & ~err_bresp) |
                      (err_orphan_nxt & ~err_orphan_b);
    end
  end

`ifdef HP_WRITE_MONITOR_STATS_EN
  // Free-running traffic counters, wrapping at 2^32.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset || clear) begin
      beat_count  <= '0;
      burst_count <= '0;
    end else begin
      if (w_hs) begin
        beat_count <= beat_count + 32'd1;
      end
      if (aw_hs) begin
        burst_count <= burst_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hp_write_monitor.sv
// tb/tb_hp_write_monitor.sv - directed scoreboard bench for hp_write_monitor
module tb_hp_write_monitor;

  logic       clk;
  logic       rst;
  logic       s_awvalid;
  logic       s_awready;
  logic [3:0] s_awlen;
  logic       m_awvalid;
  logic       m_awready;
  logic       mon_wvalid;
  logic       mon_wready;
  logic       mon_wlast;
  logic       mon_bvalid;
  logic       mon_bready;
  logic [1:0] mon_bresp;
  logic       clear;
  logic [3:0] outstanding;
  logic       err_wlast;
  logic       err_bresp;
  logic       err_orphan_b;
  logic       irq;
`ifdef HP_WRITE_MONITOR_STATS_EN
  logic [31:0] beat_count;
  logic [31:0] burst_count;
`endif

  int exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int irq_seen;

  hp_write_monitor dut (
    .axi_aclk     (clk),
    .axi_areset   (rst),
    .s_awvalid    (s_awvalid),
    .s_awready    (s_awready),
    .s_awlen      (s_awlen),
    .m_awvalid    (m_awvalid),
    .m_awready    (m_awready),
    .mon_wvalid   (mon_wvalid),
    .mon_wready   (mon_wready),
    .mon_wlast    (mon_wlast),
    .mon_bvalid   (mon_bvalid),
    .mon_bready   (mon_bready),
    .mon_bresp    (mon_bresp),
    .clear        (clear),
    .outstanding  (outstanding),
    .err_wlast    (err_wlast),
    .err_bresp    (err_bresp),
    .err_orphan_b (err_orphan_b),
    .irq          (irq)
`ifdef HP_WRITE_MONITOR_STATS_EN
    ,
    .beat_count   (beat_count),
    .burst_count  (burst_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input int obs);
    int exp_val;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      exp_val = exp_q.pop_front();
      assert (obs === exp_val) else begin
        n_errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_val);
      end
    end
  endtask

  task automatic idle();
    s_awvalid  = 1'b0;
    s_awlen    = 4'd0;
    m_awready  = 1'b0;
    mon_wvalid = 1'b0;
    mon_wready = 1'b0;
    mon_wlast  = 1'b0;
    mon_bvalid = 1'b0;
    mon_bready = 1'b0;
    mon_bresp  = 2'b00;
    clear      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic aw(input logic [3:0] len);
    s_awvalid = 1'b1;
    m_awready = 1'b1;
    s_awlen   = len;
    tick();
    s_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic last);
    mon_wvalid = 1'b1;
    mon_wready = 1'b1;
    mon_wlast  = last;
    tick();
    mon_wvalid = 1'b0;
    mon_wready = 1'b0;
    mon_wlast  = 1'b0;
  endtask

  task automatic b_resp(input logic [1:0] resp, input logic clr);
    mon_bvalid = 1'b1;
    mon_bready = 1'b1;
    mon_bresp  = resp;
    clear      = clr;
    tick();
    mon_bvalid = 1'b0;
    mon_bready = 1'b0;
    mon_bresp  = 2'b00;
    clear      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    do_reset();

    // Reset state
    m_awready = 1'b1;
    #2;
    expect_v(0); expect_v(0); expect_v(1); expect_v(1);
    check("rst_outstanding", outstanding);
    check("rst_flags", {err_wlast, err_bresp, err_orphan_b, irq});
    check("rst_awready", s_awready);
    check("rst_fifo_empty", dut.fifo_empty);

    // Eight AWs fill the window, ninth stalls until a B returns
    s_awvalid = 1'b1;
    s_awlen   = 4'd3;
    for (int i = 0; i < 8; i++) tick();
    #2;
    expect_v(8); expect_v(0); expect_v(0);
    check("fill_outstanding", outstanding);
    check("fill_s_awready", s_awready);
    check("fill_m_awvalid", m_awvalid);
    s_awvalid = 1'b0;
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 4; j++) w_beat(j == 3);
    s_awvalid = 1'b1;
    #2;
    expect_v(8); expect_v(0); expect_v(0); expect_v(1);
    check("drain_outstanding", outstanding);
    check("drain_err_wlast", err_wlast);
    check("drain_s_awready", s_awready);
    check("drain_fifo_empty", dut.fifo_empty);
    mon_bvalid = 1'b1;
    mon_bready = 1'b1;
    tick();
    mon_bvalid = 1'b0;
    mon_bready = 1'b0;
    #2;
    expect_v(7); expect_v(1); expect_v(1);
    check("b_outstanding", outstanding);
    check("b_s_awready", s_awready);
    check("b_m_awvalid", m_awvalid);
    tick();
    s_awvalid = 1'b0;
    expect_v(8); expect_v(0);
    check("ninth_outstanding", outstanding);
    check("ninth_flags", {err_wlast, err_bresp, err_orphan_b});

    // Reset with bursts in flight discards everything
    do_reset();
    expect_v(0); expect_v(1);
    check("midreset_outstanding", outstanding);
    check("midreset_fifo_empty", dut.fifo_empty);

    // AW and single-beat W in the same cycle via bypass
    s_awvalid = 1'b1; m_awready = 1'b1; s_awlen = 4'd0;
    mon_wvalid = 1'b1; mon_wready = 1'b1; mon_wlast = 1'b1;
    tick();
    idle();
    expect_v(0); expect_v(1); expect_v(1);
    check("bypass_err_wlast", err_wlast);
    check("bypass_fifo_empty", dut.fifo_empty);
    check("bypass_outstanding", outstanding);
    // Bypassed burst that continues past its first beat
    s_awvalid = 1'b1; m_awready = 1'b1; s_awlen = 4'd1;
    mon_wvalid = 1'b1; mon_wready = 1'b1; mon_wlast = 1'b0;
    tick();
    idle();
    w_beat(1'b1);
    expect_v(0); expect_v(1); expect_v(2);
    check("bypass2_err_wlast", err_wlast);
    check("bypass2_fifo_empty", dut.fifo_empty);
    check("bypass2_outstanding", outstanding);

    // Early wlast on a len=3 burst
    do_reset();
    aw(4'd3);
    w_beat(1'b0);
    w_beat(1'b0);
    w_beat(1'b1);
    expect_v(1); expect_v(1);
    check("early_err_wlast", err_wlast);
    check("early_irq", irq);
    tick();
    expect_v(0);
    check("early_irq_pulse", irq);
    irq_seen = 0;
    aw(4'd3);
    irq_seen += irq;
    for (int j = 0; j < 4; j++) begin
      w_beat(j == 3);
      irq_seen += irq;
    end
    tick();
    irq_seen += irq;
    expect_v(0); expect_v(1); expect_v(1);
    check("good_burst_irqs", irq_seen);
    check("good_burst_err_wlast", err_wlast);
    check("good_burst_fifo_empty", dut.fifo_empty);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_v(0);
    check("clear_err_wlast", err_wlast);
    w_beat(1'b1);
    expect_v(1); expect_v(1); expect_v(1);
    check("nohead_err_wlast", err_wlast);
    check("nohead_irq", irq);
    check("nohead_fifo_empty", dut.fifo_empty);

    // Error responses and clear collision
    do_reset();
    aw(4'd0);
    aw(4'd0);
    b_resp(2'b10, 1'b0);
    expect_v(1); expect_v(1); expect_v(0); expect_v(1);
    check("slverr_err_bresp", err_bresp);
    check("slverr_irq", irq);
    check("slverr_orphan", err_orphan_b);
    check("slverr_outstanding", outstanding);
    b_resp(2'b10, 1'b1);
    expect_v(1); expect_v(0); expect_v(0);
    check("clear_vs_set_err_bresp", err_bresp);
    check("clear_vs_set_irq", irq);
    check("clear_vs_set_outstanding", outstanding);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_v(0);
    check("clear_err_bresp", err_bresp);

    // Orphan B and simultaneous AW+B
    do_reset();
    b_resp(2'b00, 1'b0);
    expect_v(1); expect_v(0); expect_v(1); expect_v(0);
    check("orphan_flag", err_orphan_b);
    check("orphan_outstanding", outstanding);
    check("orphan_irq", irq);
    check("orphan_err_bresp", err_bresp);
    for (int i = 0; i < 5; i++) aw(4'd0);
    expect_v(5);
    check("five_outstanding", outstanding);
    s_awvalid = 1'b1; m_awready = 1'b1; s_awlen = 4'd0;
    mon_bvalid = 1'b1; mon_bready = 1'b1;
    tick();
    idle();
    expect_v(5); expect_v(0);
    check("awb_outstanding", outstanding);
    check("awb_irq", irq);

`ifdef HP_WRITE_MONITOR_STATS_EN
    do_reset();
    aw(4'd15);
    aw(4'd15);
    for (int b = 0; b < 2; b++)
      for (int j = 0; j < 16; j++) w_beat(j == 15);
    expect_v(32); expect_v(2); expect_v(0);
    check("stats_beats", beat_count);
    check("stats_bursts", burst_count);
    check("stats_err_wlast", err_wlast);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_v(0); expect_v(0);
    check("stats_clear_beats", beat_count);
    check("stats_clear_bursts", burst_count);
`endif

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_leftover: observed %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
